down_timer: RTL and testbench
=============================

# down_timer

Programmable down-counting timer that terminates the counting chain opposite the up counter: a period is loaded, counted down to zero, and a terminal-count pulse is emitted. It supports one-shot and auto-reload (periodic) modes, and start, pause and resume control. It sits beside the existing up counter in the datapath as the tick and timeout source for downstream control logic.

## Interface
- WIDTH, 8, bit width of period and count
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Data  input  WIDTH  period value for load
- load  input  1  write Data into reload register and count; aborts any run
- start  input  1  start, restart or resume
- pause  input  1  freeze count while running
- mode_reload  input  1  1 = periodic auto-reload, 0 = one-shot
- Q  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered, one cycle)
- busy  output  1  high in RUN or PAUSED (decoded from state register)
- done  output  1  high in DONE (decoded from state register)

## Operation
- Internal registers: reload register R (WIDTH bits), count Q, and a 2-bit state: IDLE, RUN, PAUSED, DONE.
- Per-edge priority: reset > load > start > pause > count.
- load, any state: R←Data, Q←Data, state←IDLE, tc←0.
- start in IDLE or DONE with R≠0: Q←R, state←RUN.
- start with R==0: ignored. State, Q and tc are unchanged.
- start in RUN: restart, Q←R, stays RUN.
- start in PAUSED: resume to RUN. Q is not reloaded.
- start and pause together: start wins.
- RUN with pause: state←PAUSED, Q held.
- PAUSED: Q held; pause has no further effect.
- RUN, Q>1: Q←Q−1.
- RUN, Q==1: tc←1.
  - If mode_reload=1: Q←R, stays RUN.
  - If mode_reload=0: Q←0, state←DONE.
  - mode_reload is sampled only on this edge.
- tc is 0 on every edge not listed above.
- DONE: Q holds 0 until start or load.
- Arithmetic: unsigned, WIDTH bits. Q never decrements below 1 in RUN, so no underflow wrap occurs.

## Timing
- Reset values: Q=0, R=0, state=IDLE, tc=0, busy=0, done=0.
- start sampled at edge k: Q=R after edge k; decrement begins at edge k+1.
- tc is high for the cycle after edge k+R, i.e. exactly R cycles after the start edge.
- R=1: tc after edge k+1.
- Auto-reload: tc repeats every R cycles with no gap cycle. Q sequence: R, R−1, …, 1, R, …
- Each PAUSED cycle delays tc by one cycle.
- load or reset mid-run: takes effect at that edge (reset immediately, asynchronously). No tc is emitted for the aborted period.
- busy and done change on the same edge as the state.

## Structure
- Shared header/package down_timer_defs holds:
  - state encoding localparams: IDLE=0, RUN=1, PAUSED=2, DONE=3
  - default WIDTH
- Single module with no sub-module. FSM and datapath share one sequential block; busy and done are decoded combinationally from state.

## Test plan
- Reset then load Data=5, mode_reload=0, start → Q steps 5,4,3,2,1,0. tc is one cycle high 5 cycles after the start edge; done=1, busy=0 afterward.
- Data=3, mode_reload=1, start, run 12 cycles → tc pulses at cycles 3, 6, 9, 12; Q repeats 3,2,1.
- Data=6, start, pause 2 cycles at Q=4, then start → Q holds 4 for 2 cycles, resumes 3,2,1. tc arrives 8 cycles after the first start.
- Data=4, start; at Q=2 assert load with Data=9 → Q=9, state IDLE, no tc. Then start → tc 9 cycles later.
- Data=0, start → stays IDLE, Q=0, tc never asserts. Also: start and pause in the same cycle from PAUSED → RUN.
- Async reset asserted mid-count between clock edges → Q=0, tc=0, busy=0 immediately. Counting is not resumed after reset release.

Source files
------------

// File: rtl/down_timer_defs.sv
// Shared definitions for the down_timer: state encoding and default count width.
package down_timer_defs;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = IDLE,
        S_RUN    = RUN,
        S_PAUSED = PAUSED,
        S_DONE   = DONE
    } state_t;

endpackage

// File: rtl/down_timer.sv
// Programmable down-counting timer with one-shot / auto-reload modes and
// start, pause and resume control; emits a one-cycle terminal-count pulse.
module down_timer
    import down_timer_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic             mode_reload,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic             tc_q,     tc_d;

    // Priority chain: load > start > pause > count.
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        count_d  = count_q;
        tc_d     = 1'b0;

        if (load) begin
            reload_d = Data;
            count_d  = Data;
            state_d  = S_IDLE;
        end else if (start) begin
            if (state_q == S_PAUSED) begin
                state_d = S_RUN;
            end else if (reload_q != '0) begin
                count_d = reload_q;
                state_d = S_RUN;
            end
        end else if (pause && (state_q == S_RUN)) begin
            state_d = S_PAUSED;
        end else if (state_q == S_RUN) begin
            // Count stops at 1: the terminal edge reloads or parks at zero.
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                if (mode_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            reload_q <= '0;
            count_q  <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
        end
    end

    assign Q    = count_q;
    assign tc   = tc_q;
    assign busy = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios with literal
// expectations plus a randomized run against an elapsed-time reference model.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Data;
    logic       load, start, pause, mode_reload;
    logic [7:0] Q;
    logic       tc, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    down_timer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .Data(Data), .load(load), .start(start),
        .pause(pause), .mode_reload(mode_reload), .Q(Q), .tc(tc),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: a run is described by its period R and the number of
    // counting edges elapsed since the start edge; Q and tc follow from that.
    int         m_R, m_el;
    bit         m_run, m_pause, m_done, m_tc;
    logic [7:0] m_Q;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_R = 0; m_el = 0; m_Q = 8'd0;
            m_run = 0; m_pause = 0; m_done = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (load) begin
                m_R = int'(Data); m_Q = Data;
                m_run = 0; m_pause = 0; m_done = 0;
            end else if (start && m_pause) begin
                m_pause = 0;
            end else if (start && m_R != 0) begin
                m_run = 1; m_pause = 0; m_done = 0; m_el = 0; m_Q = 8'(m_R);
            end else if (pause && m_run && !m_pause) begin
                m_pause = 1;
            end else if (m_run && !m_pause) begin
                m_el++;
                if (m_el % m_R == 0) begin
                    m_tc = 1;
                    if (mode_reload) m_Q = 8'(m_R);
                    else begin m_run = 0; m_done = 1; m_Q = 8'd0; end
                end else begin
                    m_Q = 8'(m_R - (m_el % m_R));
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_Q", 32'(Q), 32'(m_Q));
            check("model_tc", 32'(tc), 32'(m_tc));
            check("model_busy", 32'(busy), 32'(m_run));
            check("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; pause = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; Data = 0; mode_reload = 0;
        idle_inputs();
        #12;
        @(negedge clk);
        reset = 0;
        chk_en = 1;
        check("reset_Q", 32'(Q), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_tc", 32'(tc), 0);

        // One-shot, period 5
        Data = 8'd5; load = 1; cyc(); load = 0;
        check("load5_Q", 32'(Q), 5);
        start = 1; cyc(); start = 0;
        check("start5_Q", 32'(Q), 5);
        check("start5_busy", 32'(busy), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check("os_Q", 32'(Q), 32'(5 - i));
            check("os_tc", 32'(tc), (i == 5) ? 1 : 0);
        end
        check("os_done", 32'(done), 1);
        check("os_busy", 32'(busy), 0);
        cyc();
        check("os_tc_after", 32'(tc), 0);
        check("os_hold0", 32'(Q), 0);

        // Auto-reload, period 3
        Data = 8'd3; mode_reload = 1; load = 1; cyc(); load = 0;
        start = 1; cyc(); start = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check("ar_tc", 32'(tc), (i % 3 == 0) ? 1 : 0);
            check("ar_Q", 32'(Q), (i % 3 == 0) ? 3 : 32'(3 - (i % 3)));
        end
        mode_reload = 0;

        // Pause at Q=4, then start+pause together resumes from PAUSED
        Data = 8'd6; load = 1; cyc(); load = 0;
        start = 1; cyc(); start = 0;
        cyc(); cyc();
        check("pz_Q4", 32'(Q), 4);
        pause = 1; cyc();
        check("pz_held", 32'(Q), 4);
        check("pz_busy", 32'(busy), 1);
        start = 1; cyc(); start = 0; pause = 0;
        check("pz_resume_Q", 32'(Q), 4);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("pz_tc", 32'(tc), (i == 4) ? 1 : 0);
        end

        // Load aborts a run mid-count
        Data = 8'd4; load = 1; cyc(); load = 0;
        start = 1; cyc(); start = 0;
        cyc(); cyc();
        check("ab_Q2", 32'(Q), 2);
        Data = 8'd9; load = 1; cyc(); load = 0;
        check("ab_Q9", 32'(Q), 9);
        check("ab_busy", 32'(busy), 0);
        check("ab_tc", 32'(tc), 0);
        start = 1; cyc(); start = 0;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            check("ab_tc_run", 32'(tc), (i == 9) ? 1 : 0);
        end

        // Zero period: start ignored
        Data = 8'd0; load = 1; cyc(); load = 0;
        start = 1; cyc(); start = 0;
        check("z_busy", 32'(busy), 0);
        check("z_Q", 32'(Q), 0);
        cyc(); cyc();
        check("z_tc", 32'(tc), 0);

        // Asynchronous reset between edges
        Data = 8'd7; load = 1; cyc(); load = 0;
        start = 1; cyc(); start = 0;
        @(posedge clk); #2;
        reset = 1; #1;
        check("ar_rst_Q", 32'(Q), 0);
        check("ar_rst_tc", 32'(tc), 0);
        check("ar_rst_busy", 32'(busy), 0);
        @(negedge clk); cyc();
        reset = 0;
        cyc(); cyc();
        check("post_rst_Q", 32'(Q), 0);
        check("post_rst_busy", 32'(busy), 0);

        // Randomized traffic checked by the model on every cycle
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1;
                #2 reset = 0;
            end else begin
                load  = ($urandom_range(0, 15) == 0);
                Data  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
                start = ($urandom_range(0, 7) == 0);
                pause = ($urandom_range(0, 7) == 0);
                mode_reload = $urandom_range(0, 1) == 1;
            end
            cyc();
        end

        idle_inputs();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
